tristate_bus_reader: RTL

Bus-side read sequencer for a bank of tri-state-output register slots on a shared data bus. It scans the slots selected by a mask, one at a time. For each slot it drives that slot's active-low-select `cs` line (cs=1 floats the slot, cs=0 drives the bus), waits a settle interval, samples the bus, and delivers the word downstream on a valid/ready handshake. It is the consumer end of the register-bank `cs`/`Q` interface and is used for register dump, debug readout and context save in the CPU memory subsystem.

---
 rtl/tristate_bus_reader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tristate_bus_reader.sv
// -----------------------------------------------------------------------------
// tristate_bus_reader
//
// Read sequencer for a bank of tri-state register slots that share one data
// bus. It walks the slots chosen by Mask in ascending index order. For each
// slot it pulls that slot's cs line low, waits SettleCycles enabled cycles,
// samples Bus and offers the word downstream on a valid/ready handshake.
// Between two slot selections there is always at least one enabled cycle
// with every cs high, so two slots never drive the bus at the same time.
//
// Ports
//   Clock        system clock, rising edge
//   Reset        asynchronous, active-high; forces cs all ones at once
//   ClockEnable  global enable
//   Tick         rate tick; state moves only when ClockEnable & Tick
//   Start        begin a scan (taken in IDLE only)
//   Abort        synchronous abort of a running scan
//   Mask         slots to read, latched when Start is accepted
//   Bus          shared tri-state data bus (read only)
//   cs           per-slot select, active low, registered
//   OutData      captured bus word
//   OutSlot      slot index of OutData
//   OutValid     OutData/OutSlot valid
//   OutReady     downstream accepts the word
//   Busy         scan in progress (any state but IDLE)
//   Done         one-enabled-cycle pulse at scan completion
// -----------------------------------------------------------------------------
module tristate_bus_reader #(
  parameter int NrOfBits     = 8,
  parameter int NrOfSlots    = 4,
  parameter int SlotBits     = 2,
  parameter int SettleCycles = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 ClockEnable,
  input  logic                 Tick,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic [NrOfSlots-1:0] Mask,
  input  logic [NrOfBits-1:0]  Bus,
  output logic [NrOfSlots-1:0] cs,
  output logic [NrOfBits-1:0]  OutData,
  output logic [SlotBits-1:0]  OutSlot,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CntBits = (SettleCycles < 2) ? 1 : $clog2(SettleCycles + 1);
  localparam logic [CntBits-1:0] SettleLoad = CntBits'(SettleCycles);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SELECT = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  logic [1:0]           state;
  logic [NrOfSlots-1:0] pending;     // slots still to be read in this scan
  logic [SlotBits-1:0]  slot;        // slot currently selected
  logic [CntBits-1:0]   settle_cnt;
  logic                 enabled_edge;
  logic [NrOfSlots-1:0] scan_src;
  logic [SlotBits-1:0]  next_slot;

  // Index of the lowest set bit; callers only use it on a non-zero vector.
  function automatic logic [SlotBits-1:0] lowest_slot(input logic [NrOfSlots-1:0] m);
    lowest_slot = '0;
    for (int i = NrOfSlots - 1; i >= 0; i--) begin
      if (m[i]) lowest_slot = SlotBits'(i);
    end
  endfunction

  // cs pattern with exactly one slot driving the bus.
  function automatic logic [NrOfSlots-1:0] select_line(input logic [SlotBits-1:0] s);
    select_line = ~(NrOfSlots'(1) << s);
  endfunction

  assign enabled_edge = ClockEnable & Tick;
  assign Busy         = (state != IDLE);

  // In IDLE the first slot comes from the incoming Mask; afterwards it comes
  // from the latched mask, whose current slot bit has already been cleared.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal
    // holding its old value, which would infer a latch.
    scan_src = pending;
    if (state == IDLE) scan_src = Mask;
  end

  assign next_slot = lowest_slot(scan_src);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      // NOTE: sequential state uses <= so every register samples the values
      // from before the edge, independent of statement order.
      state      <= IDLE;
      cs         <= '1;
      OutData    <= '0;
      OutSlot    <= '0;
      OutValid   <= 1'b0;
      Done       <= 1'b0;
      pending    <= '0;
      slot       <= '0;
      settle_cnt <= '0;
    end else if (enabled_edge) begin
      // Done is a single enabled-cycle pulse unless re-armed below.
      Done <= 1'b0;
      if (Abort) begin
        // Abort outranks both Start and the handshake; OutData/OutSlot keep
        // their last values and no Done is produced.
        if (state != IDLE) begin
          state    <= IDLE;
          cs       <= '1;
          OutValid <= 1'b0;
          pending  <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (Start) begin
              if (Mask != '0) begin
                pending    <= Mask;
                slot       <= next_slot;
                cs         <= select_line(next_slot);
                settle_cnt <= SettleLoad;
                state      <= SELECT;
              end else begin
                // Empty scan completes immediately without touching the bus.
                Done <= 1'b1;
              end
            end
          end

          SELECT: begin
            settle_cnt <= settle_cnt - 1'b1;
            if (settle_cnt == CntBits'(1)) begin
              OutData       <= Bus;
              OutSlot       <= slot;
              OutValid      <= 1'b1;
              cs            <= '1;
              pending[slot] <= 1'b0;
              state         <= WAIT;
            end
          end

          WAIT: begin
            if (OutReady) begin
              OutValid <= 1'b0;
              if (pending != '0) begin
                slot       <= next_slot;
                cs         <= select_line(next_slot);
                settle_cnt <= SettleLoad;
                state      <= SELECT;
              end else begin
                Done  <= 1'b1;
                state <= IDLE;
              end
            end
          end

          default: begin
            state <= IDLE;
            cs    <= '1;
          end
        endcase
      end
    end
  end

endmodule
